// File: rtl/fft_frame_arbiter_if.sv
// fft_frame_arbiter_if: AXI-Stream bundle used for the requester, FFT config and FFT data channels.
interface fft_frame_arbiter_if #(parameter int W = 64);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;
    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/fft_frame_arbiter.sv
// fft_frame_arbiter: whole-frame round-robin sharing of one FFT core between two AXI-Stream requesters.
// FFT_ZERO_PAD_EN: zero-pad short frames to FFT_LEN instead of ending them early with frame_err.
module fft_frame_arbiter #(
    parameter int FFT_LEN        = 8192,
    parameter int DATA_WIDTH     = 64,
    parameter int CONFIG_LATENCY = 16
) (
    input  logic                aclk,
    input  logic                aresetn,
    fft_frame_arbiter_if.slave  s0,
    input  logic                s0_fwd_inv,
    fft_frame_arbiter_if.slave  s1,
    input  logic                s1_fwd_inv,
    fft_frame_arbiter_if.master cfg,
    fft_frame_arbiter_if.master fft,
    input  logic                fft_out_tvalid,
    input  logic                fft_out_tready,
    input  logic                fft_out_tlast,
    output logic                owner,
    output logic                busy,
    output logic                frame_err
);
    localparam int LOG2 = $clog2(FFT_LEN);
    localparam int BW = LOG2 + 1;
    localparam int WW = $clog2(CONFIG_LATENCY + 1) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(FFT_LEN - 1);
    localparam logic [WW-1:0] LAST_WAIT = WW'(CONFIG_LATENCY - 1);
`ifdef FFT_ZERO_PAD_EN
    typedef enum logic [2:0] {IDLE, CONFIG, WAIT_CFG, STREAM, ZPAD, DISCARD, DRAIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, CONFIG, WAIT_CFG, STREAM, DISCARD, DRAIN} state_t;
`endif
    state_t state, state_n;
    logic owner_n, fwd, fwd_n, last_grant, last_grant_n;
    logic [BW-1:0] beat, beat_n;
    logic [WW-1:0] wait_cnt, wait_n;
    logic [DATA_WIDTH-1:0] in_data;
    logic in_valid, in_last, in_ready, last_beat;

    assign in_data   = owner ? s1.tdata : s0.tdata;
    assign in_valid  = owner ? s1.tvalid : s0.tvalid;
    assign in_last   = owner ? s1.tlast : s0.tlast;
    assign s0.tready = in_ready & ~owner;
    assign s1.tready = in_ready & owner;
    assign busy      = state != IDLE;
    assign last_beat = beat == LAST_BEAT;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            owner      <= 1'b0;
            fwd        <= 1'b0;
            last_grant <= 1'b1;
            beat       <= '0;
            wait_cnt   <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            fwd        <= fwd_n;
            last_grant <= last_grant_n;
            beat       <= beat_n;
            wait_cnt   <= wait_n;
        end
    end

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        fwd_n        = fwd;
        last_grant_n = last_grant;
        beat_n       = beat;
        wait_n       = wait_cnt;
        in_ready     = 1'b0;
        frame_err    = 1'b0;
        cfg.tvalid   = 1'b0;
        cfg.tdata    = '0;
        cfg.tlast    = 1'b0;
        fft.tvalid   = 1'b0;
        fft.tdata    = '0;
        fft.tlast    = 1'b0;
        case (state)
            IDLE: if (s0.tvalid | s1.tvalid) begin
                owner_n = (s0.tvalid & s1.tvalid) ? ~last_grant : s1.tvalid;
                fwd_n   = owner_n ? s1_fwd_inv : s0_fwd_inv;
                state_n = CONFIG;
            end
            CONFIG: begin
                cfg.tvalid = 1'b1;
                cfg.tdata  = {7'd0, fwd, 3'd0, 5'(LOG2)};
                wait_n     = '0;
                if (cfg.tready) state_n = WAIT_CFG;
            end
            WAIT_CFG: begin
                wait_n = wait_cnt + 1'b1;
                if (wait_cnt == LAST_WAIT) begin
                    state_n = STREAM;
                    beat_n  = '0;
                end
            end
            STREAM: begin
                fft.tvalid = in_valid;
                fft.tdata  = in_data;
                in_ready   = fft.tready;
`ifdef FFT_ZERO_PAD_EN
                fft.tlast  = last_beat;
`else
                fft.tlast  = last_beat | in_last;
`endif
                if (in_valid & fft.tready) begin
                    beat_n = beat + 1'b1;
                    if (in_last & last_beat) state_n = DRAIN;
                    else if (in_last) begin
`ifdef FFT_ZERO_PAD_EN
                        state_n = ZPAD;
`else
                        frame_err = 1'b1;
                        state_n   = DRAIN;
`endif
                    end else if (last_beat) begin
                        frame_err = 1'b1;
                        state_n   = DISCARD;
                    end
                end
            end
`ifdef FFT_ZERO_PAD_EN
            ZPAD: begin
                fft.tvalid = 1'b1;
                fft.tlast  = last_beat;
                if (fft.tready) begin
                    beat_n = beat + 1'b1;
                    if (last_beat) state_n = DRAIN;
                end
            end
`endif
            DISCARD: begin
                in_ready = 1'b1;
                if (in_valid & in_last) state_n = DRAIN;
            end
            DRAIN: if (fft_out_tvalid & fft_out_tready & fft_out_tlast) begin
                last_grant_n = owner;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
